// File: rtl/pad_addr_gen_nd.sv
// rtl/pad_addr_gen_nd.sv - N-level nested-loop address generator with repeat snapshots
module pad_addr_gen_nd #(
  parameter int LOOP_NUM  = 4,
  parameter int ADDR_W    = 13,
  parameter int CNT_W     = 13,
  parameter int REC_DEPTH = 2,
  localparam int SLOT_W   = (REC_DEPTH > 1) ? $clog2(REC_DEPTH) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_W-1:0]                cfg_base_addr,
  input  logic [LOOP_NUM-1:0][ADDR_W-1:0]  cfg_gap,
  input  logic [LOOP_NUM-1:0][CNT_W-1:0]   cfg_lenth,
  input  logic                             start,
  input  logic                             abort,
  output logic                             addr_valid,
  input  logic                             addr_ready,
  output logic [ADDR_W-1:0]                addr,
  output logic                             addr_last,
  output logic                             busy,
  output logic                             done,
  input  logic                             rec_en,
  input  logic [SLOT_W-1:0]                rec_slot,
  input  logic                             repeat_init,
  input  logic [SLOT_W-1:0]                repeat_slot
);

  localparam int REC_N = 1 << SLOT_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0]               base_q;
  logic [LOOP_NUM-1:0][ADDR_W-1:0] gap_q;
  logic [LOOP_NUM-1:0][CNT_W-1:0]  lenth_q;
  logic [LOOP_NUM-1:0][CNT_W-1:0]  cnt_q, cnt_nx;
  logic [LOOP_NUM-1:0][ADDR_W-1:0] off_q, off_nx;
  logic [ADDR_W-1:0]               addr_q;
  logic [LOOP_NUM-1:0]             at_max;
  logic                            carry;
  logic [ADDR_W-1:0]               step_sum, rest_sum;
  logic                            accept;

  // Unused slots past REC_DEPTH stay at the reset snapshot.
  logic [LOOP_NUM-1:0][CNT_W-1:0]  rec_cnt [REC_N];
  logic [LOOP_NUM-1:0][ADDR_W-1:0] rec_off [REC_N];

  assign addr_valid = (state == RUN);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign addr       = addr_q;
  assign addr_last  = (state == RUN) & (&at_max);
  assign accept     = addr_valid & addr_ready;

  always_comb begin
    cnt_nx   = cnt_q;
    off_nx   = off_q;
    at_max   = '0;
    carry    = 1'b1;
    for (int i = LOOP_NUM - 1; i >= 0; i--) begin
      at_max[i] = (cnt_q[i] == lenth_q[i]);
      if (carry) begin
        if (at_max[i]) begin
          cnt_nx[i] = '0;
          off_nx[i] = '0;
        end else begin
          cnt_nx[i] = cnt_q[i] + 1'b1;
          off_nx[i] = off_q[i] + gap_q[i];
        end
      end
      carry = carry & at_max[i];
    end
    step_sum = base_q;
    rest_sum = base_q;
    for (int i = 0; i < LOOP_NUM; i++) begin
      step_sum = step_sum + off_nx[i];
      rest_sum = rest_sum + rec_off[repeat_slot][i];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        if (abort)                                     state_nx = IDLE;
        else if (!repeat_init && accept && addr_last)  state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      base_q  <= '0;
      gap_q   <= '0;
      lenth_q <= '0;
      cnt_q   <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      for (int s = 0; s < REC_N; s++) begin
        rec_cnt[s] <= '0;
        rec_off[s] <= '0;
      end
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          base_q  <= cfg_base_addr;
          gap_q   <= cfg_gap;
          lenth_q <= cfg_lenth;
          cnt_q   <= '0;
          off_q   <= '0;
          addr_q  <= cfg_base_addr;
        end
        RUN: begin
          if (rec_en && (32'(rec_slot) < REC_DEPTH)) begin
            rec_cnt[rec_slot] <= cnt_q;
            rec_off[rec_slot] <= off_q;
          end
          if (!abort) begin
            if (repeat_init) begin
              cnt_q  <= rec_cnt[repeat_slot];
              off_q  <= rec_off[repeat_slot];
              addr_q <= rest_sum;
            end else if (accept) begin
              cnt_q  <= cnt_nx;
              off_q  <= off_nx;
              addr_q <= step_sum;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pad_addr_gen_nd.sv
// tb/tb_pad_addr_gen_nd.sv - directed scoreboard bench for pad_addr_gen_nd
module tb_pad_addr_gen_nd;

  logic             clk = 1'b0;
  logic             rst;
  logic [12:0]      cfg_base_addr;
  logic [3:0][12:0] cfg_gap;
  logic [3:0][12:0] cfg_lenth;
  logic             start, abort;
  logic             addr_valid, addr_ready;
  logic [12:0]      addr;
  logic             addr_last, busy, done;
  logic             rec_en, repeat_init;
  logic [0:0]       rec_slot, repeat_slot;

  int tests = 0;
  int fails = 0;

  logic [13:0] sb [$];
  bit          stalled_prev;
  logic [14:0] held;
  bit          prev_last_acc;
  bit          done_seen;

  always #5 clk = ~clk;

  pad_addr_gen_nd dut (
    .clk(clk), .rst(rst), .cfg_base_addr(cfg_base_addr), .cfg_gap(cfg_gap),
    .cfg_lenth(cfg_lenth), .start(start), .abort(abort), .addr_valid(addr_valid),
    .addr_ready(addr_ready), .addr(addr), .addr_last(addr_last), .busy(busy),
    .done(done), .rec_en(rec_en), .rec_slot(rec_slot), .repeat_init(repeat_init),
    .repeat_slot(repeat_slot)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    stalled_prev  = 1'b0;
    prev_last_acc = 1'b0;
  endtask

  task automatic step();
    logic [13:0] e;
    if (stalled_prev) chk("stall_hold", 32'({addr_valid, addr_last, addr}), 32'(held));
    if (addr_valid && addr_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        chk("addr", 32'(addr), 32'(e[12:0]));
        chk("last", 32'(addr_last), 32'(e[13]));
      end
    end
    stalled_prev  = addr_valid && !addr_ready;
    held          = {addr_valid, addr_last, addr};
    prev_last_acc = addr_valid && addr_ready && addr_last;
    @(posedge clk); #1;
  endtask

  task automatic cfg_t1();
    cfg_base_addr = 13'h100;
    cfg_gap   = '0; cfg_gap[3] = 13'h1; cfg_gap[2] = 13'h10;
    cfg_lenth = '0; cfg_lenth[3] = 13'd2; cfg_lenth[2] = 13'd1;
  endtask

  task automatic push_t1();
    sb.push_back({1'b0, 13'h100}); sb.push_back({1'b0, 13'h101});
    sb.push_back({1'b0, 13'h102}); sb.push_back({1'b0, 13'h110});
    sb.push_back({1'b0, 13'h111}); sb.push_back({1'b1, 13'h112});
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_latency_valid", 32'(addr_valid), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic run(input int budget, input bit rnd);
    done_seen = 1'b0;
    for (int c = 0; c < budget && !done_seen; c++) begin
      addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) begin
        done_seen = 1'b1;
        chk("done_after_last", 32'(prev_last_acc), 32'd1);
        chk("done_valid_low", 32'(addr_valid), 32'd0);
      end
      step();
    end
    chk("done_seen", 32'(done_seen), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b0;
    rec_en = 1'b0; repeat_init = 1'b0; rec_slot = '0; repeat_slot = '0;
    cfg_base_addr = '0; cfg_gap = '0; cfg_lenth = '0;
    stalled_prev = 1'b0; prev_last_acc = 1'b0; held = '0;
    tick(); tick();
    chk("rst_valid", 32'(addr_valid), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // 1: basic two-loop sweep, always ready
    cfg_t1(); push_t1(); do_start();
    chk("t1_first_addr", 32'(addr), 32'h100);
    run(30, 1'b0);

    // 2: same with random backpressure
    cfg_t1(); push_t1(); do_start();
    run(300, 1'b1);

    // 3: negative stride wraps at 13 bits
    cfg_base_addr = 13'h010; cfg_gap = '0; cfg_gap[3] = 13'h1FFC;
    cfg_lenth = '0; cfg_lenth[3] = 13'd5;
    sb.push_back({1'b0, 13'h010}); sb.push_back({1'b0, 13'h00C});
    sb.push_back({1'b0, 13'h008}); sb.push_back({1'b0, 13'h004});
    sb.push_back({1'b0, 13'h000}); sb.push_back({1'b1, 13'h1FFC});
    do_start();
    run(30, 1'b0);

    // 4: record at 0x102, restore after 0x111, base change ignored
    cfg_t1(); do_start();
    cfg_base_addr = 13'h555;
    sb.push_back({1'b0, 13'h100}); sb.push_back({1'b0, 13'h101});
    sb.push_back({1'b0, 13'h102}); sb.push_back({1'b0, 13'h110});
    sb.push_back({1'b0, 13'h111}); sb.push_back({1'b0, 13'h102});
    sb.push_back({1'b0, 13'h110}); sb.push_back({1'b0, 13'h111});
    sb.push_back({1'b1, 13'h112});
    addr_ready = 1'b1; rec_slot = 1'b1; repeat_slot = 1'b1;
    for (int k = 0; k < 9; k++) begin
      rec_en      = (k == 2);
      repeat_init = (k == 4);
      step();
    end
    rec_en = 1'b0; repeat_init = 1'b0;
    run(10, 1'b0);

    // 5: abort mid-run, then clean restart
    cfg_t1(); do_start();
    sb.push_back({1'b0, 13'h100}); sb.push_back({1'b0, 13'h101});
    sb.push_back({1'b0, 13'h102});
    addr_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    chk("abort_at_addr", 32'(addr), 32'h110);
    abort = 1'b1; addr_ready = 1'b0;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(addr_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    tick();
    chk("abort_no_done_later", 32'(done), 32'd0);
    chk("abort_sb_empty", 32'(sb.size()), 32'd0);
    push_t1(); do_start();
    run(30, 1'b0);

    // 6: reset mid-run, then single-beat run
    cfg_t1(); push_t1(); do_start();
    addr_ready = 1'b1;
    step(); step();
    rst = 1'b1;
    tick();
    chk("midrst_valid", 32'(addr_valid), 32'd0);
    chk("midrst_addr", 32'(addr), 32'd0);
    chk("midrst_last", 32'(addr_last), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    rst = 1'b0;
    sb.delete();
    tick();
    cfg_base_addr = 13'h0AB; cfg_gap = '0; cfg_gap[3] = 13'h7; cfg_lenth = '0;
    sb.push_back({1'b1, 13'h0AB});
    do_start();
    chk("single_last", 32'(addr_last), 32'd1);
    run(10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pad_addr_gen_nd.md
Name: pad_addr_gen_nd

Overview:
- Parametrised N-level nested-loop address generator for the dnoc pad/DMA path.
- Replaces the fixed 4-loop, 13-bit generator.
- Adds configurable loop count and widths, signed strides, config latched at start, and a valid/ready address stream with last/done.
- Adds multi-slot repeat record/restore and abort.

Parameters:
LOOP_NUM, 4, number of nested loops; index LOOP_NUM-1 is innermost, index 0 is outermost
ADDR_W, 13, address and stride width
CNT_W, 13, loop counter width
REC_DEPTH, 2, number of repeat snapshot slots (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_base_addr  in  ADDR_W  base address
cfg_gap  in  LOOP_NUM x ADDR_W  per-loop stride, two's complement
cfg_lenth  in  LOOP_NUM x CNT_W  per-loop last index; loop i runs lenth[i]+1 iterations
start  in  1  begin a run; cfg_* sampled this cycle
abort  in  1  terminate the run
addr_valid  out  1  addr holds a valid beat
addr_ready  in  1  consumer accepts the beat
addr  out  ADDR_W  generated address
addr_last  out  1  current beat is the final one of the run
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the last beat is accepted
rec_en  in  1  snapshot counters of the current beat
rec_slot  in  max(1,$clog2(REC_DEPTH))  snapshot slot
repeat_init  in  1  restore counters from a slot
repeat_slot  in  max(1,$clog2(REC_DEPTH))  restore slot

Behaviour:
- Reset, applied at any time including mid-run:
  - state IDLE; addr=0; addr_valid=0; addr_last=0; done=0; busy=0.
  - All counters, loop offsets, latched config and snapshot slots are 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE->RUN on start: latch cfg_*; clear all counters and offsets; addr<=cfg_base_addr.
  - Latency: start at cycle T gives addr_valid=1 at T+1.
  - RUN->DONE when the beat with addr_last=1 is accepted.
  - DONE->IDLE unconditionally; done=1 only while in DONE.
  - RUN->IDLE on abort (priority over accept and restore); no done pulse.
  - start is ignored outside IDLE. abort is ignored in IDLE and DONE.
- addr_valid = (state==RUN), registered.
- Beat accept = addr_valid & addr_ready.
  - While addr_valid=1 and addr_ready=0, addr and addr_last must hold stable.
- Counter advance on accept:
  - Innermost loop always steps.
  - Loop i steps only when every loop j>i has cnt[j]==lenth[j].
  - Step: if cnt[i]==lenth[i], set cnt[i]=0 and off[i]=0; else cnt[i]+=1 and off[i]+=gap[i].
  - Offsets wrap modulo 2^ADDR_W.
- addr <= base + sum(off_next[i]), modulo 2^ADDR_W, registered; it updates only on start, accept or restore.
- addr_last = RUN & AND over i of (cnt[i]==lenth[i]). It is decoded from registered counters; there is no extra cycle of latency.
- Total beats per run = product of (lenth[i]+1). lenth all zero gives a single beat at base with addr_last=1.
- rec_en is honoured only in RUN and captures cnt/off of the beat currently on addr, independent of accept. If rec_en and repeat_init are asserted together, the record captures the pre-restore counters.
- repeat_init is honoured only in RUN.
  - Next cycle: cnt/off = slot contents and addr = base + sum of slot offsets.
  - Restore has priority over a simultaneous accept; that accepted beat is consumed and not re-issued.
  - Restoring a never-written slot yields the reset snapshot, i.e. addr = base.
- Config inputs may change freely while busy without effect.

Test Plan:
1. LOOP_NUM=4; base=0x100; gap[3]=1, gap[2]=0x10; lenth[3]=2, lenth[2]=1, others 0; addr_ready=1 -> addr 0x100,0x101,0x102,0x110,0x111,0x112 on consecutive cycles starting at T+1; addr_last only on 0x112; done pulse on the following cycle; busy drops after it.
2. Same config with addr_ready toggled pseudo-randomly -> identical six-address sequence, no duplicates or skips, addr stable while stalled.
3. base=0x010; gap[3]=0x1FFC (-4); lenth[3]=5 -> 0x010,0x00C,0x008,0x004,0x000,0x1FFC (13-bit wrap), last on 0x1FFC.
4. Config of test 1:
   - rec_en with rec_slot=1 while addr=0x102.
   - Later, after 0x111 is accepted, repeat_init with repeat_slot=1 -> next addr 0x102, then 0x110,0x111,0x112 with last.
   - Changing cfg_base_addr mid-run has no effect.
5. abort while 0x110 is on the bus -> addr_valid=0 next cycle, no done; a new start yields 0x100 first.
6. rst asserted mid-run -> next cycle all outputs 0 and state IDLE. start with all lenth=0 and base=0x0AB -> single beat 0x0AB with addr_last=1, then done.
